// File: rtl/alu_seq_pkg.sv
// Shared constants and state encoding for alu_op_sequencer.
// Imported by the sequencer top.
package alu_seq_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_ADD = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SUB = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/adder_subtracter.sv
// Combinational ripple adder/subtracter datapath.
// command=1 inverts b; carryin supplies the +1 of two's complement.
module adder_subtracter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             command,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;

  assign bx = b ^ {WIDTH{command}};

  assign {carryout, sum} = {1'b0, a}
                         + {1'b0, bx}
                         + {{WIDTH{1'b0}}, carryin};

  assign overflow = (a[WIDTH-1] == bx[WIDTH-1])
                  & (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked front end giving the adder a fixed settle window.
// Define ALU_SEQ_SATURATE_EN to clamp signed-overflow results.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [CMD_W-1:0] req_cmd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_error
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CMD_W-1:0] cmd_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             err_q;

  logic             is_sub;
  logic             legal;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_cout;
  logic             alu_ovf;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  logic             err_d;

  assign is_sub = (cmd_q == CMD_SUB);
  assign legal  = (cmd_q == CMD_ADD) | is_sub;

  adder_subtracter #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .carryin  (is_sub),
    .command  (is_sub),
    .sum      (alu_sum),
    .carryout (alu_cout),
    .overflow (alu_ovf)
  );

  always_comb begin
    res_d = alu_sum;
`ifdef ALU_SEQ_SATURATE_EN
    // Wrapped MSB=1 means the true result was positive.
    if (alu_ovf) begin
      res_d = alu_sum[WIDTH-1]
            ? {1'b0, {(WIDTH-1){1'b1}}}
            : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
    if (!legal) res_d = '0;
    carry_d = legal & alu_cout;
    ovf_d   = legal & alu_ovf;
    zero_d  = legal & (res_d == '0);
    err_d   = ~legal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q         <= req_a;
            b_q         <= req_b;
            cmd_q       <= req_cmd;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            res_q       <= res_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = carry_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;
  assign rsp_error    = err_q;

endmodule
